serial_rho_stream: RTL and testbench

//  Streaming, column-serial successor to the combinational rho column mix for SWAN-family datapaths.

---
 rtl/serial_rho_stream_pkg.sv | 12 +
 rtl/serial_rho_stream_bank.sv | 77 +++++++
 rtl/serial_rho_stream.sv | 102 ++++++++++
 tb/tb_serial_rho_stream.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_rho_stream_pkg.sv
// Shared definitions for the column-serial rho mix: default geometry and bank state encodings.
package serial_rho_stream_pkg;

    localparam int unsigned DEF_COLUMN_SIZE = 16;
    localparam int unsigned DEF_NUM_COL     = 4;

    typedef enum logic [1:0] {
        BANK_LOAD = 2'd0,
        BANK_EMIT = 2'd1
    } bank_state_e;

endpackage

// File: rtl/serial_rho_stream_bank.sv
// One rho bank: column buffer, running XOR accumulator, position counter and LOAD/EMIT state.
// A single position counter serves as the load count in LOAD and the emit index in EMIT,
// since the two are never live at the same time.
module serial_rho_stream_bank
    import serial_rho_stream_pkg::*;
#(
    parameter int unsigned COLUMN_SIZE = DEF_COLUMN_SIZE,
    parameter int unsigned NUM_COL     = DEF_NUM_COL
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [0:COLUMN_SIZE-1] wr_data,
    input  logic                   rd_en,
    output logic                   load_c,
    output logic                   emit_c,
    output logic                   last_c,
    output logic [0:COLUMN_SIZE-1] rd_data_c
);

    localparam int unsigned CNT_W = $clog2(NUM_COL);

    bank_state_e            state_q;
    logic [CNT_W-1:0]       pos_q;
    logic [0:COLUMN_SIZE-1] acc_q;
    logic [0:COLUMN_SIZE-1] buf_q [NUM_COL];

    assign load_c    = (state_q == BANK_LOAD);
    assign emit_c    = (state_q == BANK_EMIT);
    assign last_c    = (pos_q == CNT_W'(NUM_COL - 1));
    assign rd_data_c = acc_q ^ buf_q[pos_q];

    // Bank FSM: accumulate T while loading, then walk the buffer while emitting.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BANK_LOAD;
            pos_q   <= '0;
            acc_q   <= '0;
        end else begin
            case (state_q)
                BANK_LOAD: begin
                    if (wr_en) begin
                        acc_q <= acc_q ^ wr_data;
                        if (last_c) begin
                            pos_q   <= '0;
                            state_q <= BANK_EMIT;
                        end else begin
                            pos_q <= pos_q + CNT_W'(1);
                        end
                    end
                end
                BANK_EMIT: begin
                    if (rd_en) begin
                        if (last_c) begin
                            pos_q   <= '0;
                            acc_q   <= '0;
                            state_q <= BANK_LOAD;
                        end else begin
                            pos_q <= pos_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= BANK_LOAD;
                end
            endcase
        end
    end

    // Column storage; contents need no reset because the state machine never reads stale entries.
    always_ff @(posedge clk) begin
        if (!rst && state_q == BANK_LOAD && wr_en) begin
            buf_q[pos_q] <= wr_data;
        end
    end

endmodule

// File: rtl/serial_rho_stream.sv
// Column-serial rho mix: each block of NUM_COL columns a[k] yields b[k] = T ^ a[k], T = XOR of the block.
// Build option RHO_DOUBLE_BUF_EN: two banks in ping-pong for one column per cycle on both sides;
// without it a single bank alternates between loading and emitting.
module serial_rho_stream
    import serial_rho_stream_pkg::*;
#(
    parameter int unsigned COLUMN_SIZE = DEF_COLUMN_SIZE,
    parameter int unsigned NUM_COL     = DEF_NUM_COL
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [0:COLUMN_SIZE-1] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [0:COLUMN_SIZE-1] out_data,
    output logic                   out_last
);

    logic in_fire;
    logic out_fire;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

`ifdef RHO_DOUBLE_BUF_EN

    logic                   load_ptr_q;
    logic                   emit_ptr_q;
    logic [1:0]             bank_load;
    logic [1:0]             bank_emit;
    logic [1:0]             bank_last;
    logic [0:COLUMN_SIZE-1] bank_data [2];

    // Handshakes depend only on bank state and pointers, never on out_ready.
    assign in_ready  = !rst && bank_load[load_ptr_q];
    assign out_valid = !rst && bank_emit[emit_ptr_q];
    assign out_data  = bank_data[emit_ptr_q];
    assign out_last  = out_valid && bank_last[emit_ptr_q];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        serial_rho_stream_bank #(
            .COLUMN_SIZE (COLUMN_SIZE),
            .NUM_COL     (NUM_COL)
        ) u_bank (
            .clk       (clk),
            .rst       (rst),
            .wr_en     (in_fire && (load_ptr_q == 1'(b))),
            .wr_data   (in_data),
            .rd_en     (out_fire && (emit_ptr_q == 1'(b))),
            .load_c    (bank_load[b]),
            .emit_c    (bank_emit[b]),
            .last_c    (bank_last[b]),
            .rd_data_c (bank_data[b])
        );
    end

    // Ping-pong pointers advance when their bank completes a block on that side.
    always_ff @(posedge clk) begin
        if (rst) begin
            load_ptr_q <= 1'b0;
            emit_ptr_q <= 1'b0;
        end else begin
            if (in_fire && bank_last[load_ptr_q]) begin
                load_ptr_q <= !load_ptr_q;
            end
            if (out_fire && bank_last[emit_ptr_q]) begin
                emit_ptr_q <= !emit_ptr_q;
            end
        end
    end

`else

    logic bank_load;
    logic bank_emit;
    logic bank_last;

    // Single bank: input side open only in LOAD, output side only in EMIT.
    assign in_ready  = !rst && bank_load;
    assign out_valid = !rst && bank_emit;
    assign out_last  = out_valid && bank_last;

    serial_rho_stream_bank #(
        .COLUMN_SIZE (COLUMN_SIZE),
        .NUM_COL     (NUM_COL)
    ) u_bank (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (in_fire),
        .wr_data   (in_data),
        .rd_en     (out_fire),
        .load_c    (bank_load),
        .emit_c    (bank_emit),
        .last_c    (bank_last),
        .rd_data_c (out_data)
    );

`endif

endmodule

// File: tb/tb_serial_rho_stream.sv
// Self-checking bench for serial_rho_stream: table vectors, random stalls, involution,
// mid-block reset, a NUM_COL=3 instance and a throughput run (build-dependent expectation).
module tb_serial_rho_stream;

    typedef struct {
        logic [15:0] data;
        logic        last;
    } exp_t;

    typedef struct {
        logic [15:0] din  [4];
        logic [15:0] dout [4];
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic        out_last;

    logic        in_valid3 = 1'b0;
    logic        in_ready3;
    logic [7:0]  in_data3 = '0;
    logic        out_valid3;
    logic        out_ready3 = 1'b1;
    logic [7:0]  out_data3;
    logic        out_last3;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t        sb_q [$];
    logic [15:0] cap_q [$];
    logic [15:0] blk [4];
    int          blk_n = 0;
    bit          rand_rdy = 1'b0;

    bit          prev_stall = 1'b0;
    logic [15:0] prev_data;
    logic        prev_last;
    int          run = 0;
    int          max_run = 0;
    int          ready_in_emit = 0;
    exp_t        mon_e;

    serial_rho_stream #(.COLUMN_SIZE(16), .NUM_COL(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    serial_rho_stream #(.COLUMN_SIZE(8), .NUM_COL(3)) u_dut3 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .in_data   (in_data3),
        .out_valid (out_valid3),
        .out_ready (out_ready3),
        .out_data  (out_data3),
        .out_last  (out_last3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Downstream ready: always 1, or a coin flip per cycle.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor / scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
            run = 0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_data", 32'(out_data), 32'(prev_data));
                chk("stall_last", 32'(out_last), 32'(prev_last));
            end
            if (out_valid && out_ready) begin
                cap_q.push_back(out_data);
                run++;
                if (run > max_run) max_run = run;
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %h expected none", out_data);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("out_data", 32'(out_data), 32'(mon_e.data));
                    chk("out_last", 32'(out_last), 32'(mon_e.last));
                end
            end else begin
                run = 0;
            end
            if (out_valid && in_ready) ready_in_emit++;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Send one column; when model is set, push the model's block result on block completion.
    task automatic send_col(input logic [15:0] d, input bit model);
        logic [15:0] t;
        in_valid = 1'b1;
        in_data  = d;
        for (int w = 0; ; w++) begin
            @(negedge clk);
            if (in_ready) break;
            if (w > 1000) begin
                chk("in_ready_timeout", 32'd0, 32'd1);
                in_valid = 1'b0;
                return;
            end
        end
        tick();
        in_valid = 1'b0;
        if (model) begin
            blk[blk_n] = d;
            blk_n++;
            if (blk_n == 4) begin
                t = blk[0] ^ blk[1] ^ blk[2] ^ blk[3];
                for (int i = 0; i < 4; i++) sb_q.push_back('{data: t ^ blk[i], last: (i == 3)});
                blk_n = 0;
            end
        end
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 3000 && sb_q.size() != 0; t++) tick();
        chk("drain", 32'(sb_q.size()), 32'd0);
    endtask

    vec_t        tbl [5];
    logic [15:0] x [4];
    logic [15:0] fb [4];
    logic [7:0]  d3 [6];
    logic [7:0]  e3 [6];
    logic        l3 [6];
    logic [7:0]  g3d [$];
    logic        g3l [$];
    int          i3;
    bit          acc3;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0].din = '{16'h0001, 16'h0002, 16'h0004, 16'h0008};
        tbl[0].dout = '{16'h000E, 16'h000D, 16'h000B, 16'h0007};
        tbl[1].din = '{16'hFFFF, 16'h0000, 16'h0000, 16'h0000};
        tbl[1].dout = '{16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        tbl[2].din = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
        tbl[2].dout = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
        tbl[3].din = '{16'hAAAA, 16'h5555, 16'hFFFF, 16'h0000};
        tbl[3].dout = '{16'hAAAA, 16'h5555, 16'hFFFF, 16'h0000};
        tbl[4].din = '{16'h1234, 16'h1234, 16'h0001, 16'h0000};
        tbl[4].dout = '{16'h1235, 16'h1235, 16'h0000, 16'h0001};

        // Reset state
        repeat (3) tick();
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        tick();

        // Table vectors, with a latency check on the first block
        for (int v = 0; v < 5; v++) begin
            for (int c = 0; c < 4; c++) send_col(tbl[v].din[c], 1'b0);
            for (int c = 0; c < 4; c++) sb_q.push_back('{data: tbl[v].dout[c], last: (c == 3)});
            if (v == 0) begin
                @(negedge clk);
                chk("latency_valid", 32'(out_valid), 32'd1);
                chk("latency_data", 32'(out_data), 32'h000E);
                tick();
            end
        end
        wait_drain();

        // Random blocks with random downstream stalls and input gaps
        rand_rdy = 1'b1;
        for (int b = 0; b < 100; b++) begin
            for (int c = 0; c < 4; c++) begin
                if ($urandom_range(0, 3) == 0) tick();
                send_col(16'($urandom_range(0, 65535)), 1'b1);
            end
        end
        wait_drain();

        // Involution: a block's outputs fed back reproduce the block
        for (int r = 0; r < 3; r++) begin
            cap_q.delete();
            for (int c = 0; c < 4; c++) begin
                x[c] = 16'($urandom_range(0, 65535));
                send_col(x[c], 1'b1);
            end
            wait_drain();
            chk("invol_count", 32'(cap_q.size()), 32'd4);
            for (int c = 0; c < 4; c++) fb[c] = (cap_q.size() > c) ? cap_q[c] : 16'h0;
            for (int c = 0; c < 4; c++) send_col(fb[c], 1'b0);
            for (int c = 0; c < 4; c++) sb_q.push_back('{data: x[c], last: (c == 3)});
            wait_drain();
        end
        rand_rdy = 1'b0;
        repeat (2) tick();

        // Reset after two columns: partial block must vanish
        send_col(16'h1111, 1'b1);
        send_col(16'h2222, 1'b1);
        rst = 1'b1;
        blk_n = 0;
        @(negedge clk);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_release_ready", 32'(in_ready), 32'd1);
        chk("midrst_release_valid", 32'(out_valid), 32'd0);
        tick();
        for (int c = 0; c < 4; c++) send_col(tbl[1].din[c], 1'b0);
        for (int c = 0; c < 4; c++) sb_q.push_back('{data: tbl[1].dout[c], last: (c == 3)});
        wait_drain();

        // NUM_COL=3, COLUMN_SIZE=8 instance: two blocks to exercise counter wrap
        d3 = '{8'h11, 8'h22, 8'h44, 8'h01, 8'h02, 8'h03};
        e3 = '{8'h66, 8'h55, 8'h33, 8'h01, 8'h02, 8'h03};
        l3 = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        i3 = 0;
        in_valid3 = 1'b1;
        in_data3  = d3[0];
        for (int cyc = 0; cyc < 80 && g3d.size() < 6; cyc++) begin
            @(negedge clk);
            acc3 = in_valid3 && in_ready3;
            if (out_valid3) begin
                g3d.push_back(out_data3);
                g3l.push_back(out_last3);
            end
            tick();
            if (acc3) begin
                i3++;
                if (i3 < 6) in_data3 = d3[i3];
                else in_valid3 = 1'b0;
            end
        end
        in_valid3 = 1'b0;
        chk("n3_count", 32'(g3d.size()), 32'd6);
        for (int k = 0; k < 6; k++) begin
            if (k < g3d.size()) begin
                chk("n3_data", 32'(g3d[k]), 32'(e3[k]));
                chk("n3_last", 32'(g3l[k]), 32'(l3[k]));
            end
        end

        // Throughput run: 8 blocks with in_valid and out_ready held high
        repeat (2) tick();
        max_run = 0;
        ready_in_emit = 0;
        for (int c = 0; c < 32; c++) send_col(16'($urandom_range(0, 65535)), 1'b1);
        wait_drain();
`ifdef RHO_DOUBLE_BUF_EN
        chk("stream_run", 32'(max_run), 32'd32);
`else
        chk("single_run", 32'(max_run), 32'd4);
        chk("ready_in_emit", 32'(ready_in_emit), 32'd0);
`endif

        repeat (4) tick();
        chk("final_idle_valid", 32'(out_valid), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
